bomb_put_arbiter: RTL and testbench

Sits between the player input/movement logic and the bomb grid. Turns raw per-player place-bomb requests into one-cycle put commands the grid consumes, with per-player capacity limits, an occupied-tile check and same-tile conflict resolution between P1 and P2. Each player also gets a bank of fuse-slot timers that yields a live bomb count, so capacity is enforced here and not in the grid.

---
 rtl/bomb_pkg.sv | 25 ++
 rtl/bomb_slot_bank.sv | 65 ++++++
 rtl/bomb_put_arbiter.sv | 118 +++++++++++
 tb/tb_bomb_put_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_pkg.sv
// Shared types and defaults for the bomb put arbiter: tile geometry, length code,
// player identifiers and the capacity clamp helper.
package bomb_pkg;

    localparam int TILE_W          = 8;
    localparam int GRID_W          = 16;
    localparam int TILE_CNT        = GRID_W * GRID_W;
    localparam int DEF_MAX_CAP     = 4;
    localparam int DEF_SLOT_CYCLES = 61;

    typedef logic [1:0]        len_t;
    typedef logic [TILE_W-1:0] cor_t;
    typedef enum logic { P1 = 1'b0, P2 = 1'b1 } player_e;

    function automatic logic [2:0] clamp_cap(input logic [2:0] cap, input logic [2:0] max_cap);
        logic [2:0] res;
        if (cap > max_cap) begin
            res = max_cap;
        end else begin
            res = cap;
        end
        return res;
    endfunction

endpackage

// File: rtl/bomb_slot_bank.sv
// Per-player bank of fuse-slot timers; a grant loads the lowest free slot and
// each occupied slot releases itself after SLOT_CYCLES cycles.
module bomb_slot_bank
    import bomb_pkg::*;
#(
    parameter int MAX_CAP     = DEF_MAX_CAP,
    parameter int SLOT_CYCLES = DEF_SLOT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       grant,
    output logic       slot_free,
    output logic [2:0] bomb_num
);

    localparam int            CW   = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(SLOT_CYCLES - 1);

    logic [MAX_CAP-1:0] valid_r;
    logic [CW-1:0]      cnt_r [MAX_CAP];
    logic [MAX_CAP-1:0] sel_s;
    logic               found_s;
    logic [2:0]         pop_s;

    assign slot_free = ~&valid_r;

    // One-hot lowest free slot and occupancy popcount
    always_comb begin
        sel_s   = '0;
        found_s = 1'b0;
        pop_s   = 3'd0;
        for (int i = 0; i < MAX_CAP; i++) begin
            sel_s[i] = ~valid_r[i] & ~found_s;
            found_s  = found_s | ~valid_r[i];
            pop_s    = pop_s + {2'b00, valid_r[i]};
        end
    end

    // Slot load, count-up and release at terminal count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r  <= '0;
            bomb_num <= 3'd0;
            for (int i = 0; i < MAX_CAP; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_CAP; i++) begin
                if (grant && sel_s[i]) begin
                    valid_r[i] <= 1'b1;
                    cnt_r[i]   <= '0;
                end else if (valid_r[i] && (cnt_r[i] == TERM)) begin
                    valid_r[i] <= 1'b0;
                    cnt_r[i]   <= '0;
                end else if (valid_r[i]) begin
                    cnt_r[i]   <= cnt_r[i] + CW'(1);
                end else begin
                    cnt_r[i]   <= '0;
                end
            end
            bomb_num <= pop_s;
        end
    end

endmodule

// File: rtl/bomb_put_arbiter.sv
// Turns P1/P2 place-bomb button edges into one-cycle grid put commands or denies.
// Define BOMB_ARB_RR_EN to alternate same-tile conflict wins; otherwise P1 always wins.
module bomb_put_arbiter
    import bomb_pkg::*;
#(
    parameter int MAX_CAP     = DEF_MAX_CAP,
    parameter int SLOT_CYCLES = DEF_SLOT_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                p1_req,
    input  logic                p2_req,
    input  logic [TILE_W-1:0]   p1_cor,
    input  logic [TILE_W-1:0]   p2_cor,
    input  logic [1:0]          p1_bomb_len,
    input  logic [1:0]          p2_bomb_len,
    input  logic [2:0]          p1_bomb_cap,
    input  logic [2:0]          p2_bomb_cap,
    input  logic [TILE_CNT-1:0] tile_busy,
    output logic                p1_put,
    output logic                p2_put,
    output logic [TILE_W-1:0]   p1_put_cor,
    output logic [TILE_W-1:0]   p2_put_cor,
    output logic [1:0]          p1_put_len,
    output logic [1:0]          p2_put_len,
    output logic                p1_deny,
    output logic                p2_deny,
    output logic [2:0]          bomb_num_p1,
    output logic [2:0]          bomb_num_p2
);

    logic p1_req_d_r, p2_req_d_r;
    logic p1_free_s, p2_free_s;
    logic req1_s, req2_s, elig1_s, elig2_s;
    logic conflict_s, p1_wins_s, grant1_s, grant2_s, deny1_s, deny2_s;
`ifdef BOMB_ARB_RR_EN
    player_e prio_r;
`endif

    // Eligibility and same-tile resolution, all from registered state
    always_comb begin
        req1_s  = p1_req & ~p1_req_d_r;
        req2_s  = p2_req & ~p2_req_d_r;
        // The put shadow blocks a tile while the grid has not yet marked it busy
        elig1_s = req1_s & p1_free_s
                & (bomb_num_p1 < clamp_cap(p1_bomb_cap, 3'(MAX_CAP)))
                & ~tile_busy[p1_cor]
                & ~(p1_put & (p1_put_cor == p1_cor))
                & ~(p2_put & (p2_put_cor == p1_cor));
        elig2_s = req2_s & p2_free_s
                & (bomb_num_p2 < clamp_cap(p2_bomb_cap, 3'(MAX_CAP)))
                & ~tile_busy[p2_cor]
                & ~(p1_put & (p1_put_cor == p2_cor))
                & ~(p2_put & (p2_put_cor == p2_cor));
        conflict_s = elig1_s & elig2_s & (p1_cor == p2_cor);
`ifdef BOMB_ARB_RR_EN
        p1_wins_s = (prio_r == P1);
`else
        p1_wins_s = 1'b1;
`endif
        grant1_s = elig1_s & (~conflict_s | p1_wins_s);
        grant2_s = elig2_s & (~conflict_s | ~p1_wins_s);
        deny1_s  = req1_s & ~grant1_s;
        deny2_s  = req2_s & ~grant2_s;
    end

    // Registered put/deny pulses, edge-detect history and conflict priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1_req_d_r <= 1'b0;
            p2_req_d_r <= 1'b0;
            p1_put     <= 1'b0;
            p2_put     <= 1'b0;
            p1_put_cor <= '0;
            p2_put_cor <= '0;
            p1_put_len <= 2'b00;
            p2_put_len <= 2'b00;
            p1_deny    <= 1'b0;
            p2_deny    <= 1'b0;
`ifdef BOMB_ARB_RR_EN
            prio_r     <= P1;
`endif
        end else begin
            p1_req_d_r <= p1_req;
            p2_req_d_r <= p2_req;
            p1_put     <= grant1_s;
            p2_put     <= grant2_s;
            p1_put_cor <= grant1_s ? p1_cor : '0;
            p2_put_cor <= grant2_s ? p2_cor : '0;
            p1_put_len <= grant1_s ? p1_bomb_len : 2'b00;
            p2_put_len <= grant2_s ? p2_bomb_len : 2'b00;
            p1_deny    <= deny1_s;
            p2_deny    <= deny2_s;
`ifdef BOMB_ARB_RR_EN
            if (conflict_s) begin
                prio_r <= p1_wins_s ? P2 : P1;
            end
`endif
        end
    end

    bomb_slot_bank #(.MAX_CAP(MAX_CAP), .SLOT_CYCLES(SLOT_CYCLES)) u_bank_p1 (
        .clk       (clk),
        .reset     (reset),
        .grant     (grant1_s),
        .slot_free (p1_free_s),
        .bomb_num  (bomb_num_p1)
    );

    bomb_slot_bank #(.MAX_CAP(MAX_CAP), .SLOT_CYCLES(SLOT_CYCLES)) u_bank_p2 (
        .clk       (clk),
        .reset     (reset),
        .grant     (grant2_s),
        .slot_free (p2_free_s),
        .bomb_num  (bomb_num_p2)
    );

endmodule

// File: tb/tb_bomb_put_arbiter.sv
// Scoreboard bench for bomb_put_arbiter: tasks push expected put/deny events,
// a negedge monitor pops and compares them, tasks check bomb counts inline.
module tb_bomb_put_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         p1_req = 1'b0, p2_req = 1'b0;
    logic [7:0]   p1_cor = 8'h00, p2_cor = 8'h00;
    logic [1:0]   p1_bomb_len = 2'd3, p2_bomb_len = 2'd1;
    logic [2:0]   p1_bomb_cap = 3'd2, p2_bomb_cap = 3'd4;
    logic [255:0] tile_busy = '0;
    logic         p1_put, p2_put, p1_deny, p2_deny;
    logic [7:0]   p1_put_cor, p2_put_cor;
    logic [1:0]   p1_put_len, p2_put_len;
    logic [2:0]   bomb_num_p1, bomb_num_p2;

    typedef struct {
        int         due;
        bit         put;
        bit         deny;
        logic [7:0] cor;
        logic [1:0] len;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    bomb_put_arbiter dut (
        .clk(clk), .reset(reset),
        .p1_req(p1_req), .p2_req(p2_req),
        .p1_cor(p1_cor), .p2_cor(p2_cor),
        .p1_bomb_len(p1_bomb_len), .p2_bomb_len(p2_bomb_len),
        .p1_bomb_cap(p1_bomb_cap), .p2_bomb_cap(p2_bomb_cap),
        .tile_busy(tile_busy),
        .p1_put(p1_put), .p2_put(p2_put),
        .p1_put_cor(p1_put_cor), .p2_put_cor(p2_put_cor),
        .p1_put_len(p1_put_len), .p2_put_len(p2_put_len),
        .p1_deny(p1_deny), .p2_deny(p2_deny),
        .bomb_num_p1(bomb_num_p1), .bomb_num_p2(bomb_num_p2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e1 = q1.pop_front();
            checks++;
            if (p1_put !== e1.put || p1_deny !== e1.deny ||
                (e1.put && (p1_put_cor !== e1.cor || p1_put_len !== e1.len))) begin
                errors++;
                $display("FAIL p1_sb cyc=%0d got put=%b deny=%b cor=%h len=%0d exp put=%b deny=%b cor=%h len=%0d",
                         cyc, p1_put, p1_deny, p1_put_cor, p1_put_len, e1.put, e1.deny, e1.cor, e1.len);
            end
        end else begin
            checks++;
            if ({p1_put, p1_deny} !== 2'b00) begin
                errors++;
                $display("FAIL p1_idle cyc=%0d got put=%b deny=%b exp 0 0", cyc, p1_put, p1_deny);
            end
        end
        if (q2.size() > 0 && q2[0].due == cyc) begin
            e2 = q2.pop_front();
            checks++;
            if (p2_put !== e2.put || p2_deny !== e2.deny ||
                (e2.put && (p2_put_cor !== e2.cor || p2_put_len !== e2.len))) begin
                errors++;
                $display("FAIL p2_sb cyc=%0d got put=%b deny=%b cor=%h len=%0d exp put=%b deny=%b cor=%h len=%0d",
                         cyc, p2_put, p2_deny, p2_put_cor, p2_put_len, e2.put, e2.deny, e2.cor, e2.len);
            end
        end else begin
            checks++;
            if ({p2_put, p2_deny} !== 2'b00) begin
                errors++;
                $display("FAIL p2_idle cyc=%0d got put=%b deny=%b exp 0 0", cyc, p2_put, p2_deny);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout cyc=%0d exp finish", cyc);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    // kind: 0 none, 1 put, 2 deny; called just after a posedge
    task automatic press(input bit r1, input bit r2, input logic [7:0] c1,
                         input logic [7:0] c2, input int k1, input int k2);
        exp_t e;
        p1_cor = c1; p2_cor = c2; p1_req = r1; p2_req = r2;
        if (k1 != 0) begin
            e.due = cyc + 1; e.put = (k1 == 1); e.deny = (k1 == 2);
            e.cor = c1; e.len = p1_bomb_len; q1.push_back(e);
        end
        if (k2 != 0) begin
            e.due = cyc + 1; e.put = (k2 == 1); e.deny = (k2 == 2);
            e.cor = c2; e.len = p2_bomb_len; q2.push_back(e);
        end
        tick();
        p1_req = 1'b0; p2_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({p1_put, p2_put, p1_deny, p2_deny, bomb_num_p1, bomb_num_p2} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outs got %b exp 0", {p1_put, p2_put, p1_deny, p2_deny, bomb_num_p1, bomb_num_p2});
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int n;
        p1_bomb_cap = 3'd2; p1_bomb_len = 2'd2;
        n = cyc;
        press(1'b1, 1'b0, 8'h12, 8'h00, 1, 0);
        to_neg(n + 2);
        checks++;
        if (bomb_num_p1 !== 3'd1) begin
            errors++; $display("FAIL single_num_up got=%0d exp=1", bomb_num_p1);
        end
        to_neg(n + 62);
        checks++;
        if (bomb_num_p1 !== 3'd1) begin
            errors++; $display("FAIL single_num_last got=%0d exp=1", bomb_num_p1);
        end
        to_neg(n + 63);
        checks++;
        if (bomb_num_p1 !== 3'd0) begin
            errors++; $display("FAIL single_num_free got=%0d exp=0", bomb_num_p1);
        end
        tick();
    endtask

    task automatic test_capacity();
        int n;
        p1_bomb_cap = 3'd1;
        n = cyc;
        press(1'b1, 1'b0, 8'h20, 8'h00, 1, 0);
        repeat (3) tick();
        press(1'b1, 1'b0, 8'h21, 8'h00, 2, 0);
        while (cyc < n + 64) tick();
        press(1'b1, 1'b0, 8'h22, 8'h00, 1, 0);
    endtask

    task automatic test_conflict();
        p1_bomb_cap = 3'd7;
        p2_bomb_cap = 3'd4;
        press(1'b1, 1'b1, 8'h33, 8'h33, 1, 2);
`ifdef BOMB_ARB_RR_EN
        press(1'b1, 1'b1, 8'h33, 8'h33, 2, 1);
`else
        press(1'b1, 1'b1, 8'h33, 8'h33, 1, 2);
`endif
    endtask

    task automatic test_shadow();
        exp_t e;
        p1_cor = 8'h40; p1_req = 1'b1;
        e.due = cyc + 1; e.put = 1'b1; e.deny = 1'b0; e.cor = 8'h40; e.len = p1_bomb_len;
        q1.push_back(e);
        tick();
        p1_req = 1'b0; p2_cor = 8'h40; p2_req = 1'b1;
        e.due = cyc + 1; e.put = 1'b0; e.deny = 1'b1; e.cor = 8'h40; e.len = p2_bomb_len;
        q2.push_back(e);
        tick();
        p2_req = 1'b0;
        tick();
    endtask

    task automatic test_tile_cap();
        tile_busy[8'h55] = 1'b1;
        press(1'b0, 1'b1, 8'h00, 8'h55, 0, 2);
        tile_busy = '0;
        p2_bomb_cap = 3'd0;
        press(1'b0, 1'b1, 8'h00, 8'h56, 0, 2);
        p2_bomb_cap = 3'd4;
    endtask

    task automatic test_held();
        exp_t e;
        int   puts;
        puts = 0;
        p2_cor = 8'h60; p2_req = 1'b1;
        e.due = cyc + 1; e.put = 1'b1; e.deny = 1'b0; e.cor = 8'h60; e.len = p2_bomb_len;
        q2.push_back(e);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            puts += int'(p2_put);
        end
        tick();
        p2_req = 1'b0;
        tick();
        checks++;
        if (puts !== 1) begin
            errors++; $display("FAIL held_puts got=%0d exp=1", puts);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        p1_bomb_cap = 3'd4;
        repeat (5) tick();
        press(1'b1, 1'b0, 8'h70, 8'h00, 1, 0);
        press(1'b1, 1'b0, 8'h71, 8'h00, 1, 0);
        n = cyc;
        press(1'b1, 1'b0, 8'h72, 8'h00, 1, 0);
        to_neg(n + 2);
        checks++;
        if (bomb_num_p1 !== 3'd3) begin
            errors++; $display("FAIL mid_num_live got=%0d exp=3", bomb_num_p1);
        end
        tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({p1_put, p2_put, p1_deny, p2_deny, bomb_num_p1, bomb_num_p2} !== 10'd0) begin
            errors++;
            $display("FAIL mid_reset_outs got %b exp 0", {p1_put, p2_put, p1_deny, p2_deny, bomb_num_p1, bomb_num_p2});
        end
        repeat (2) tick();
        reset = 1'b1;
        tick();
        n = cyc;
        press(1'b1, 1'b1, 8'h75, 8'h76, 1, 1);
        to_neg(n + 2);
        checks++;
        if ({bomb_num_p1, bomb_num_p2} !== {3'd1, 3'd1}) begin
            errors++; $display("FAIL after_reset_num got=%0d/%0d exp=1/1", bomb_num_p1, bomb_num_p2);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_capacity();
        test_conflict();
        test_shadow();
        test_tile_cap();
        test_held();
        test_reset_mid();
        repeat (3) tick();
        checks++;
        if (q1.size() + q2.size() !== 0) begin
            errors++; $display("FAIL sb_drain got=%0d pending exp=0", q1.size() + q2.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
